// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA overlay types: game state and health bar colours
package vga_pkg;

  typedef enum logic [1:0] {
    PLAYING = 2'd0,
    CAT_WON = 2'd1,
    DOG_WON = 2'd2,
    DRAW    = 2'd3
  } game_state_t;

  localparam logic [11:0] HP_FULL_RGB  = 12'h0C0;
  localparam logic [11:0] HP_EMPTY_RGB = 12'h400;
  localparam logic [11:0] HP_WIN_RGB   = 12'hFF0;

  // Winner's remaining segments are highlighted once the round is over.
  function automatic logic [11:0] seg_rgb(input logic filled, input logic win);
    if (!filled) return HP_EMPTY_RGB;
    return win ? HP_WIN_RGB : HP_FULL_RGB;
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing and pixel bundle passed between pipeline stages
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport vga_in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport vga_out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/hp_tracker.sv
// rtl/hp_tracker.sv - per-player hit edge detect, invulnerability lockout and saturating HP
module hp_tracker
  import vga_pkg::*;
#(
  parameter int MAX_HP        = 10,
  parameter int DMG           = 1,
  parameter int LOCKOUT_TICKS = 32_500_000,
  parameter int HPW           = $clog2(MAX_HP + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hit,
  input  logic           enable,
  input  logic           restart,
  output logic [HPW-1:0] hp,
  output logic           hit_accepted
);

  localparam logic [HPW-1:0] HP_INIT   = HPW'(MAX_HP);
  localparam logic [HPW-1:0] DMG_W     = HPW'(DMG);
  localparam logic [25:0]    LOCK_INIT = 26'(LOCKOUT_TICKS - 1);

  logic           hit_q;
  logic [25:0]    lock_q, lock_d;
  logic [HPW-1:0] hp_q, hp_d;
  logic           hit_edge;

  assign hit_edge     = hit & ~hit_q;
  assign hit_accepted = hit_edge && (lock_q == '0) && enable && !restart;
  assign hp           = hp_q;

  // Edges that land inside the lockout are dropped, not remembered.
  always_comb begin
    hp_d   = hp_q;
    lock_d = lock_q;
    if (restart) begin
      hp_d   = HP_INIT;
      lock_d = '0;
    end else if (hit_accepted) begin
      hp_d   = (hp_q > DMG_W) ? hp_q - DMG_W : '0;
      lock_d = LOCK_INIT;
    end else if (lock_q != '0) begin
      lock_d = lock_q - 26'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      lock_q <= '0;
      hp_q   <= HP_INIT;
    end else begin
      hit_q  <= hit;
      lock_q <= lock_d;
      hp_q   <= hp_d;
    end
  end

endmodule

// File: rtl/draw_hp_bars.sv
// rtl/draw_hp_bars.sv - HP tracking, game-over FSM and health bar overlay on the VGA stream
module draw_hp_bars
  import vga_pkg::*;
#(
  parameter int MAX_HP        = 10,
  parameter int DMG           = 1,
  parameter int LOCKOUT_TICKS = 32_500_000,
  parameter int SEG_W         = 20,
  parameter int BAR_H         = 16,
  parameter int BAR_Y         = 40,
  parameter int CAT_BAR_X     = 64,
  parameter int DOG_BAR_X     = 760,
  localparam int HPW          = $clog2(MAX_HP + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hit_cat,
  input  logic           hit_dog,
  input  logic           new_game,
  output logic [HPW-1:0] hp_cat,
  output logic [HPW-1:0] hp_dog,
  output logic [1:0]     game_state,
  vga_if.vga_in          vga_in,
  vga_if.vga_out         vga_out
);

  localparam logic [15:0] SEG_W16  = 16'(SEG_W);
  localparam logic [15:0] BAR_LEN  = 16'(MAX_HP * SEG_W);
  localparam logic [15:0] MAX_HP16 = 16'(MAX_HP);
  localparam logic [15:0] CAT_X0   = 16'(CAT_BAR_X);
  localparam logic [15:0] DOG_X0   = 16'(DOG_BAR_X);
  localparam logic [15:0] BAR_Y0   = 16'(BAR_Y);
  localparam logic [15:0] BAR_Y1   = 16'(BAR_Y + BAR_H);
  localparam logic [HPW-1:0] HP_INIT = HPW'(MAX_HP);

  game_state_t    state_q, state_d;
  logic           playing;
  logic           cat_acc, dog_acc;
  logic           cat_acc_q, dog_acc_q;
  logic [HPW-1:0] disp_cat_q, disp_dog_q;

  assign playing    = (state_q == PLAYING);
  assign game_state = state_q;

  hp_tracker #(
    .MAX_HP(MAX_HP), .DMG(DMG), .LOCKOUT_TICKS(LOCKOUT_TICKS), .HPW(HPW)
  ) u_cat_hp (
    .clk(clk), .rst_n(rst_n), .hit(hit_cat), .enable(playing), .restart(new_game),
    .hp(hp_cat), .hit_accepted(cat_acc)
  );

  hp_tracker #(
    .MAX_HP(MAX_HP), .DMG(DMG), .LOCKOUT_TICKS(LOCKOUT_TICKS), .HPW(HPW)
  ) u_dog_hp (
    .clk(clk), .rst_n(rst_n), .hit(hit_dog), .enable(playing), .restart(new_game),
    .hp(hp_dog), .hit_accepted(dog_acc)
  );

  // HP can only reach zero through an accepted hit, so the FSM looks one cycle behind it.
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = PLAYING;
    end else if (state_q == PLAYING) begin
      if (cat_acc_q && hp_cat == '0 && dog_acc_q && hp_dog == '0) state_d = DRAW;
      else if (dog_acc_q && hp_dog == '0)                         state_d = CAT_WON;
      else if (cat_acc_q && hp_cat == '0)                         state_d = DOG_WON;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PLAYING;
      cat_acc_q  <= 1'b0;
      dog_acc_q  <= 1'b0;
      disp_cat_q <= HP_INIT;
      disp_dog_q <= HP_INIT;
    end else begin
      state_q   <= state_d;
      cat_acc_q <= cat_acc;
      dog_acc_q <= dog_acc;
      if (vga_in.vblnk) begin
        disp_cat_q <= hp_cat;
        disp_dog_q <= hp_dog;
      end
    end
  end

  logic [15:0] h16, v16, disp_cat16, disp_dog16;
  logic [15:0] cat_fill_len, dog_gap_len;
  logic        in_rows, in_cat, in_dog, cat_filled, dog_filled;
  logic        cat_win, dog_win, blanking;
  logic [11:0] rgb_d;

  assign h16        = {5'd0, vga_in.hcount};
  assign v16        = {5'd0, vga_in.vcount};
  assign disp_cat16 = {{(16-HPW){1'b0}}, disp_cat_q};
  assign disp_dog16 = {{(16-HPW){1'b0}}, disp_dog_q};

  assign cat_fill_len = disp_cat16 * SEG_W16;
  assign dog_gap_len  = (MAX_HP16 - disp_dog16) * SEG_W16;

  assign in_rows    = (v16 >= BAR_Y0) && (v16 < BAR_Y1);
  assign in_cat     = in_rows && (h16 >= CAT_X0) && (h16 < CAT_X0 + BAR_LEN);
  assign in_dog     = in_rows && (h16 >= DOG_X0) && (h16 < DOG_X0 + BAR_LEN);
  assign cat_filled = (h16 - CAT_X0) < cat_fill_len;
  assign dog_filled = h16 >= (DOG_X0 + dog_gap_len);

  assign cat_win  = (state_q == CAT_WON) || (state_q == DRAW);
  assign dog_win  = (state_q == DOG_WON) || (state_q == DRAW);
  assign blanking = vga_in.vblnk || vga_in.hblnk;

  always_comb begin
    rgb_d = vga_in.rgb;
    if (!blanking) begin
      if (in_cat)      rgb_d = seg_rgb(cat_filled, cat_win);
      else if (in_dog) rgb_d = seg_rgb(dog_filled, dog_win);
    end
  end

  logic [10:0] vcount_q, hcount_q;
  logic        vsync_q, vblnk_q, hsync_q, hblnk_q;
  logic [11:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_q <= '0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      vcount_q <= vga_in.vcount;
      vsync_q  <= vga_in.vsync;
      vblnk_q  <= vga_in.vblnk;
      hcount_q <= vga_in.hcount;
      hsync_q  <= vga_in.hsync;
      hblnk_q  <= vga_in.hblnk;
      rgb_q    <= rgb_d;
    end
  end

  assign vga_out.vcount = vcount_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.hcount = hcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_hp_bars.sv
// tb/tb_draw_hp_bars.sv - directed self-checking bench for draw_hp_bars
module tb_draw_hp_bars;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hit_cat, hit_dog, new_game;
  logic [3:0] hp_cat, hp_dog;
  logic [1:0] game_state;
  int         checks = 0;
  int         errors = 0;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  draw_hp_bars #(
    .MAX_HP(10), .DMG(1), .LOCKOUT_TICKS(50), .SEG_W(20), .BAR_H(16),
    .BAR_Y(40), .CAT_BAR_X(64), .DOG_BAR_X(760)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hit_cat(hit_cat), .hit_dog(hit_dog), .new_game(new_game),
    .hp_cat(hp_cat), .hp_dog(hp_dog), .game_state(game_state),
    .vga_in(vin), .vga_out(vout)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_pix(input int h, input int v, input logic hb, input logic vb,
                         input logic [11:0] rgb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.rgb    = rgb;
    @(negedge clk);
  endtask

  task automatic latch_frame;
    put_pix(0, 0, 1'b1, 1'b1, 12'h000);
    put_pix(0, 0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic pulse_hit(input logic cat, input logic dog);
    hit_cat = cat;
    hit_dog = dog;
    @(negedge clk);
    hit_cat = 1'b0;
    hit_dog = 1'b0;
  endtask

  task automatic restart_game;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic test_reset;
    int          hs[6];
    int          vs[6];
    logic        hb[6];
    logic [11:0] ex[6];
    hs = '{64, 263, 264, 63, 64, 100};
    vs = '{40, 55, 40, 40, 56, 45};
    hb = '{0, 0, 0, 0, 0, 1};
    ex = '{12'h0C0, 12'h0C0, 12'h123, 12'h123, 12'h123, 12'h123};
    rst_n = 1'b0; hit_cat = 1'b0; hit_dog = 1'b0; new_game = 1'b0;
    put_pix(100, 45, 1'b0, 1'b0, 12'hABC);
    tick(2);
    checks++;
    if (hp_cat !== 4'd10 || hp_dog !== 4'd10) begin
      errors++; $display("FAIL reset_hp: got %0d/%0d expected 10/10", hp_cat, hp_dog);
    end
    checks++;
    if (game_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", game_state);
    end
    checks++;
    if (vout.rgb !== 12'h000 || vout.hcount !== 11'd0 || vout.vcount !== 11'd0) begin
      errors++; $display("FAIL reset_vga_out: rgb %h h %0d v %0d expected all 0", vout.rgb, vout.hcount, vout.vcount);
    end
    rst_n = 1'b1;
    latch_frame;
    for (int i = 0; i < 6; i++) begin
      put_pix(hs[i], vs[i], hb[i], 1'b0, 12'h123);
      checks++;
      if (vout.rgb !== ex[i] || vout.hcount !== 11'(hs[i]) || vout.vcount !== 11'(vs[i])) begin
        errors++;
        $display("FAIL idle_pix%0d: got rgb %h at (%0d,%0d) expected rgb %h at (%0d,%0d)",
                 i, vout.rgb, vout.hcount, vout.vcount, ex[i], hs[i], vs[i]);
      end
    end
  endtask

  task automatic test_held_hit;
    int         changes = 0;
    logic [3:0] prev;
    prev = hp_dog;
    hit_dog = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hp_dog !== prev) changes++;
      prev = hp_dog;
      if (i == 0) begin
        checks++;
        if (hp_dog !== 4'd9) begin
          errors++; $display("FAIL held_first: got %0d expected 9", hp_dog);
        end
      end
    end
    hit_dog = 1'b0;
    checks++;
    if (changes != 1 || hp_dog !== 4'd9 || hp_cat !== 4'd10) begin
      errors++; $display("FAIL held_once: changes %0d hp_dog %0d hp_cat %0d expected 1/9/10", changes, hp_dog, hp_cat);
    end
    tick(60);
  endtask

  task automatic test_lockout;
    for (int c = 0; c < 70; c++) begin
      hit_cat = (c == 0 || c == 20 || c == 60);
      @(negedge clk);
      if (c == 0 || c == 20 || c == 59) begin
        checks++;
        if (hp_cat !== 4'd9) begin
          errors++; $display("FAIL lockout_c%0d: got %0d expected 9", c + 1, hp_cat);
        end
      end
      if (c == 60) begin
        checks++;
        if (hp_cat !== 4'd8) begin
          errors++; $display("FAIL lockout_c61: got %0d expected 8", hp_cat);
        end
      end
    end
    hit_cat = 1'b0;
    tick(60);
  endtask

  task automatic test_restart_priority;
    new_game = 1'b1;
    hit_cat  = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++;
    if (hp_cat !== 4'd10 || hp_dog !== 4'd10 || game_state !== 2'd0) begin
      errors++; $display("FAIL restart_prio: got %0d/%0d state %0d expected 10/10 state 0", hp_cat, hp_dog, game_state);
    end
    @(negedge clk);
    checks++;
    if (hp_cat !== 4'd10) begin
      errors++; $display("FAIL restart_held: got %0d expected 10", hp_cat);
    end
    hit_cat = 1'b0;
    tick(2);
  endtask

  task automatic test_tearing;
    latch_frame;
    pulse_hit(1'b1, 1'b0);
    checks++;
    if (hp_cat !== 4'd9) begin
      errors++; $display("FAIL tear_hp: got %0d expected 9", hp_cat);
    end
    put_pix(254, 40, 1'b0, 1'b0, 12'h123);
    tick(5);
    put_pix(254, 41, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h0C0) begin
      errors++; $display("FAIL tear_midframe: got %h expected 0c0", vout.rgb);
    end
    latch_frame;
    put_pix(254, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h400) begin
      errors++; $display("FAIL tear_after_vblnk: got %h expected 400", vout.rgb);
    end
    put_pix(243, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h0C0) begin
      errors++; $display("FAIL cat_last_seg: got %h expected 0c0", vout.rgb);
    end
    pulse_hit(1'b0, 1'b1);
    latch_frame;
    put_pix(770, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h400) begin
      errors++; $display("FAIL dog_drained: got %h expected 400", vout.rgb);
    end
    put_pix(780, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h0C0) begin
      errors++; $display("FAIL dog_first_full: got %h expected 0c0", vout.rgb);
    end
    put_pix(960, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h123) begin
      errors++; $display("FAIL dog_right_edge: got %h expected 123", vout.rgb);
    end
    tick(60);
  endtask

  task automatic test_mid_reset;
    pulse_hit(1'b1, 1'b0);
    put_pix(64, 40, 1'b0, 1'b0, 12'h123);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hp_cat !== 4'd10 || vout.rgb !== 12'h000 || vout.hcount !== 11'd0) begin
      errors++; $display("FAIL async_reset: hp_cat %0d rgb %h h %0d expected 10/000/0", hp_cat, vout.rgb, vout.hcount);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_hit(1'b1, 1'b0);
    checks++;
    if (hp_cat !== 4'd9) begin
      errors++; $display("FAIL reset_clears_lock: got %0d expected 9", hp_cat);
    end
    tick(60);
  endtask

  task automatic test_win;
    restart_game;
    for (int k = 0; k < 10; k++) begin
      pulse_hit(1'b0, 1'b1);
      if (k < 9) tick(54);
    end
    checks++;
    if (hp_dog !== 4'd0 || game_state !== 2'd0) begin
      errors++; $display("FAIL win_n1: hp_dog %0d state %0d expected 0/0", hp_dog, game_state);
    end
    @(negedge clk);
    checks++;
    if (game_state !== 2'd1) begin
      errors++; $display("FAIL win_state: got %0d expected 1", game_state);
    end
    latch_frame;
    put_pix(64, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'hFF0) begin
      errors++; $display("FAIL win_colour: got %h expected ff0", vout.rgb);
    end
    put_pix(760, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h400) begin
      errors++; $display("FAIL loser_empty: got %h expected 400", vout.rgb);
    end
    tick(55);
    pulse_hit(1'b1, 1'b1);
    tick(1);
    checks++;
    if (hp_cat !== 4'd10 || hp_dog !== 4'd0 || game_state !== 2'd1) begin
      errors++; $display("FAIL win_ignores_hits: %0d/%0d state %0d expected 10/0 state 1", hp_cat, hp_dog, game_state);
    end
  endtask

  task automatic test_simultaneous;
    restart_game;
    for (int k = 0; k < 9; k++) begin
      pulse_hit(1'b1, 1'b1);
      tick(54);
    end
    checks++;
    if (hp_cat !== 4'd1 || hp_dog !== 4'd1 || game_state !== 2'd0) begin
      errors++; $display("FAIL simul_pre: %0d/%0d state %0d expected 1/1 state 0", hp_cat, hp_dog, game_state);
    end
    pulse_hit(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (hp_cat !== 4'd0 || hp_dog !== 4'd0 || game_state !== 2'd3) begin
      errors++; $display("FAIL draw: %0d/%0d state %0d expected 0/0 state 3", hp_cat, hp_dog, game_state);
    end
    put_pix(64, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'hFF0) begin
      errors++; $display("FAIL draw_colour: got %h expected ff0", vout.rgb);
    end
    latch_frame;
    put_pix(64, 40, 1'b0, 1'b0, 12'h123);
    checks++;
    if (vout.rgb !== 12'h400) begin
      errors++; $display("FAIL draw_empty: got %h expected 400", vout.rgb);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_held_hit;
    test_lockout;
    test_restart_priority;
    test_tearing;
    test_mid_reset;
    test_win;
    test_simultaneous;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
